dsp_acc_quant_fix26: RTL and testbench

- Downstream stage of the 4-way 8b x 16b fixed-point multiply-add DSP block.
- Consumes the DSP block's 26-bit signed partial sums and accumulates them over a dot-product window. The window is delimited by first/last tags that enter alongside the DSP operands.
- Rounds, shifts and saturates each completed sum to 8-bit signed, then presents it through a 2-entry valid/ready output buffer.
- Sits between the DSP column and the output/pooling path of a PE lane.

---
 rtl/dsp_acc_quant_fix26_if.sv | 42 ++++
 rtl/dsp_acc_quant_fix26.sv | 202 ++++++++++++++++++++
 tb/tb_dsp_acc_quant_fix26.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_acc_quant_fix26_if.sv
// Operand, result and output-buffer signals of the DSP accumulate/quantize stage.
// The master drives operands and consumes results; the slave is the stage.
interface dsp_acc_quant_fix26_if #(
  parameter int OUT_W = 8
);
  logic                    op_valid;
  logic                    op_first;
  logic                    op_last;
  logic [4:0]              frac_shift;
  logic signed [25:0]      result_in;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_ready;
  logic                    ovf_sticky;
  logic                    clr_ovf;

  modport master (
    output op_valid,
    output op_first,
    output op_last,
    output frac_shift,
    output result_in,
    output out_ready,
    output clr_ovf,
    input  out_valid,
    input  out_data,
    input  ovf_sticky
  );

  modport slave (
    input  op_valid,
    input  op_first,
    input  op_last,
    input  frac_shift,
    input  result_in,
    input  out_ready,
    input  clr_ovf,
    output out_valid,
    output out_data,
    output ovf_sticky
  );
endinterface

// File: rtl/dsp_acc_quant_fix26.sv
// Accumulate DSP partial sums per window, round/shift/saturate, 2-entry out buffer.
// Define DSP_ACC_SAT_EN for a saturating (instead of wrapping) accumulator.
module dsp_acc_quant_fix26 #(
  parameter int DSP_LATENCY = 2,
  parameter int ACC_W       = 32,
  parameter int OUT_W       = 8
) (
  input  logic clock0,
  input  logic aclr0,
  dsp_acc_quant_fix26_if.slave bus
);

  localparam logic signed [OUT_W-1:0] Q_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] Q_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // tag delay line: {valid, first, last}
  logic [2:0] r_tag [DSP_LATENCY];
  logic       w_a_valid;
  logic       w_a_first;
  logic       w_a_last;

  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      for (int i = 0; i < DSP_LATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= {bus.op_valid, bus.op_first, bus.op_last};
      for (int i = 1; i < DSP_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign w_a_valid = r_tag[DSP_LATENCY-1][2];
  assign w_a_first = r_tag[DSP_LATENCY-1][1];
  assign w_a_last  = r_tag[DSP_LATENCY-1][0];

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_sext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic [4:0]              r_shift;
  logic [4:0]              w_shift_nxt;

  assign w_sext = {{(ACC_W-26){bus.result_in[25]}}, bus.result_in};
  assign w_sum  = r_acc + w_sext;

`ifdef DSP_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] A_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] A_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic r_sat;
  logic w_sat_nxt;
  logic w_ovp;
  logic w_ovn;

  assign w_ovp = ~r_acc[ACC_W-1] & ~w_sext[ACC_W-1] & w_sum[ACC_W-1];
  assign w_ovn = r_acc[ACC_W-1] & w_sext[ACC_W-1] & ~w_sum[ACC_W-1];

  // once pinned, the sum stays at the rail until the next window starts
  always_comb begin
    w_acc_nxt = r_acc;
    w_sat_nxt = r_sat;
    if (w_a_valid) begin
      if (w_a_first) begin
        w_acc_nxt = w_sext;
        w_sat_nxt = 1'b0;
      end else if (!r_sat) begin
        unique case (1'b1)
          w_ovp: begin
            w_acc_nxt = A_MAX;
            w_sat_nxt = 1'b1;
          end
          w_ovn: begin
            w_acc_nxt = A_MIN;
            w_sat_nxt = 1'b1;
          end
          default: w_acc_nxt = w_sum;
        endcase
      end
    end
  end

  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      r_sat <= 1'b0;
    end else begin
      r_sat <= w_sat_nxt;
    end
  end
`else
  always_comb begin
    w_acc_nxt = r_acc;
    if (w_a_valid) begin
      w_acc_nxt = w_a_first ? w_sext : w_sum;
    end
  end
`endif

  assign w_shift_nxt = (w_a_valid && w_a_first) ? bus.frac_shift : r_shift;

  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      r_acc   <= '0;
      r_shift <= '0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // quant stage captures the completed sum
  logic                    r_q_val;
  logic signed [ACC_W-1:0] r_q_acc;
  logic [4:0]              r_q_sh;

  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      r_q_val <= 1'b0;
      r_q_acc <= '0;
      r_q_sh  <= '0;
    end else begin
      r_q_val <= w_a_valid & w_a_last;
      if (w_a_valid && w_a_last) begin
        r_q_acc <= w_acc_nxt;
        r_q_sh  <= w_shift_nxt;
      end
    end
  end

  logic [ACC_W:0]          w_one;
  logic [ACC_W:0]          w_bias;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_shr;
  logic                    w_fit;
  logic signed [OUT_W-1:0] w_q;

  assign w_one  = {{ACC_W{1'b0}}, 1'b1};
  assign w_bias = (r_q_sh != 5'd0) ? (w_one << (r_q_sh - 5'd1)) : '0;
  // one guard bit keeps the rounding bias from wrapping the sum
  assign w_rnd  = {r_q_acc[ACC_W-1], r_q_acc} + w_bias;
  assign w_shr  = w_rnd >>> r_q_sh;
  assign w_fit  = (&w_shr[ACC_W:OUT_W-1]) | ~(|w_shr[ACC_W:OUT_W-1]);

  always_comb begin
    w_q = w_shr[OUT_W-1:0];
    if (!w_fit) begin
      w_q = w_shr[ACC_W] ? Q_MIN : Q_MAX;
    end
  end

  // 2-entry output buffer
  logic signed [OUT_W-1:0] r_mem [2];
  logic                    r_wr;
  logic                    r_rd;
  logic [1:0]              r_cnt;
  logic                    r_ovf;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_push;
  logic                    w_drop;

  assign w_pop  = (r_cnt != 2'd0) & bus.out_ready;
  assign w_full = (r_cnt == 2'd2);
  assign w_push = r_q_val & (~w_full | w_pop);
  assign w_drop = r_q_val & w_full & ~w_pop;

  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_cnt    <= 2'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_q;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = (r_cnt != 2'd0);
  assign bus.out_data   = r_mem[r_rd];
  assign bus.ovf_sticky = r_ovf;

endmodule

// File: tb/tb_dsp_acc_quant_fix26.sv
// Scoreboard bench: window sums modelled at issue time, buffer modelled as a queue.
// Honours DSP_ACC_SAT_EN the same way as the design.
module tb_dsp_acc_quant_fix26;
  localparam int LAT   = 2;
  localparam int ACC_W = 32;
  localparam int OUT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp_acc_quant_fix26_if #(.OUT_W(OUT_W)) bus ();

  dsp_acc_quant_fix26 #(
    .DSP_LATENCY(LAT),
    .ACC_W(ACC_W),
    .OUT_W(OUT_W)
  ) dut (
    .clock0(clk),
    .aclr0(rst),
    .bus(bus)
  );

  typedef struct {
    int val;
    int pc;
  } exp_t;

  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  exp_t   exp_q[$];
  int     mq[$];
  bit     m_ovf;
  longint m_acc;
  int     m_sh;
  bit     m_sat;
  bit     s_v[16];
  int     s_val[16];
  int     s_sh[16];
  int     rdy_mode;
  bit     clr_req;
  bit     rnd_clr;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(string nm, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, req);
    end
  endtask

  function automatic longint wrapw(longint v);
    longint m = 64'sd1 <<< ACC_W;
    longint t = v & (m - 1);
    if (t >= m / 2) t -= m;
    return t;
  endfunction

  function automatic int quant(longint s, int sh);
    longint r = s;
    if (sh > 0) r = r + (64'sd1 <<< (sh - 1));
    r = r >>> sh;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  task automatic model_op(bit f, bit l, int sh, int val, int n);
    longint s;
    exp_t e;
    if (f) begin
      m_acc = val;
      m_sh  = sh;
      m_sat = 1'b0;
    end else if (!m_sat) begin
      s = m_acc + val;
`ifdef DSP_ACC_SAT_EN
      if (s > (64'sd1 <<< (ACC_W - 1)) - 1) begin
        m_acc = (64'sd1 <<< (ACC_W - 1)) - 1;
        m_sat = 1'b1;
      end else if (s < -(64'sd1 <<< (ACC_W - 1))) begin
        m_acc = -(64'sd1 <<< (ACC_W - 1));
        m_sat = 1'b1;
      end else begin
        m_acc = s;
      end
`else
      m_acc = wrapw(s);
`endif
    end
    if (l) begin
      e.val = quant(m_acc, m_sh);
      e.pc  = n + LAT + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic step(bit v, bit f, bit l, int sh, int val);
    int slot;
    int ns;
    @(posedge clk);
    #1;
    slot = cyc % 16;
    bus.result_in  = s_v[slot] ? 26'(s_val[slot]) : 26'($urandom);
    bus.frac_shift = s_v[slot] ? 5'(s_sh[slot]) : 5'($urandom);
    s_v[slot] = 1'b0;
    bus.op_valid = v;
    bus.op_first = v ? f : 1'($urandom);
    bus.op_last  = v ? l : 1'($urandom);
    if (v) begin
      ns = (cyc + LAT) % 16;
      s_v[ns]   = 1'b1;
      s_val[ns] = val;
      s_sh[ns]  = sh;
      model_op(f, l, sh, val, cyc);
    end
    case (rdy_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 99) < 70);
    endcase
    bus.clr_ovf = clr_req | (rnd_clr && $urandom_range(0, 99) < 3);
    clr_req = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic clear_model();
    m_acc = 0;
    m_sh  = 0;
    m_sat = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) s_v[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    #2;
    rst = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  // monitor: compare against the queue model, then advance it across the edge
  always @(negedge clk) begin
    bit pop;
    bit full;
    bit drop;
    exp_t e;
    if (rst) begin
      chk("rst_valid", longint'(bus.out_valid), 0);
      chk("rst_data", longint'(bus.out_data), 0);
      chk("rst_ovf", longint'(bus.ovf_sticky), 0);
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      chk("out_valid", longint'(bus.out_valid), longint'(mq.size() != 0));
      if (mq.size() != 0 && bus.out_valid)
        chk("out_data", longint'(bus.out_data), longint'(mq[0]));
      chk("ovf_sticky", longint'(bus.ovf_sticky), longint'(m_ovf));
      while (exp_q.size() != 0 && exp_q[0].pc < cyc) begin
        bad++;
        $display("FAIL stale_expect: entry for cycle %0d not consumed at %0d",
                 exp_q[0].pc, cyc);
        void'(exp_q.pop_front());
      end
      full = (mq.size() == 2);
      pop  = (mq.size() != 0) && bus.out_ready;
      drop = 1'b0;
      if (pop) void'(mq.pop_front());
      if (exp_q.size() != 0 && exp_q[0].pc == cyc) begin
        e = exp_q.pop_front();
        if (full && !pop) drop = 1'b1;
        else mq.push_back(e.val);
      end
      if (drop) m_ovf = 1'b1;
      else if (bus.clr_ovf) m_ovf = 1'b0;
    end
  end

  initial begin
    logic signed [25:0] rv;
    int n;
    int sh;
    bus.op_valid   = 1'b0;
    bus.op_first   = 1'b0;
    bus.op_last    = 1'b0;
    bus.frac_shift = '0;
    bus.result_in  = '0;
    bus.out_ready  = 1'b0;
    bus.clr_ovf    = 1'b0;
    rdy_mode = 1;
    clr_req  = 1'b0;
    rnd_clr  = 1'b0;
    m_ovf    = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;

    step(1, 1, 0, 4, 100);
    step(1, 0, 0, 4, 200);
    step(1, 0, 0, 4, -50);
    step(1, 0, 1, 4, 6);
    idle(6);

    step(1, 1, 0, 4, 3000);
    step(1, 0, 1, 4, 2000);
    step(1, 1, 0, 4, -2000);
    step(1, 0, 1, 4, -1000);
    step(1, 1, 1, 4, -24);
    idle(6);

    rdy_mode = 0;
    step(1, 1, 1, 4, 16);
    step(1, 1, 1, 4, 32);
    step(1, 1, 1, 4, 48);
    idle(6);
    chk("ovf_set", longint'(bus.ovf_sticky), 1);
    clr_req = 1'b1;
    idle(3);
    chk("ovf_clr", longint'(bus.ovf_sticky), 0);
    rdy_mode = 1;
    idle(4);

    step(1, 1, 0, 4, 7);
    step(1, 0, 0, 4, 9);
    do_reset();
    step(1, 1, 1, 4, 80);
    idle(6);

    step(1, 1, 0, 10, 1024);
    idle(1);
    step(1, 0, 0, 10, 1024);
    idle(1);
    step(1, 0, 0, 10, 1024);
    idle(1);
    step(1, 0, 1, 10, 1024);
    idle(6);

    step(1, 1, 0, 24, 26'h1FFFFFF);
    for (int i = 0; i < 68; i++) step(1, 0, 0, 24, 26'h1FFFFFF);
    step(1, 0, 1, 24, 26'h1FFFFFF);
    idle(6);

    rdy_mode = 2;
    rnd_clr  = 1'b1;
    for (int w = 0; w < 300; w++) begin
      n  = $urandom_range(1, 6);
      sh = $urandom_range(0, 24);
      if ($urandom_range(0, 99) < 5) begin
        rv = 26'($urandom_range(0, 4095)) - 26'sd2048;
        step(1, 0, 0, sh, int'(rv));
      end
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 99) < 30) idle($urandom_range(1, 2));
        if ($urandom_range(0, 1) == 0) rv = 26'($urandom);
        else rv = 26'($urandom_range(0, 8191)) - 26'sd4096;
        step(1, k == 0, k == n - 1, sh, int'(rv));
      end
    end

    rdy_mode = 1;
    rnd_clr  = 1'b0;
    idle(12);
    chk("end_valid", longint'(bus.out_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
